// File: rtl/reduction_seq_ctrl.sv
// Sequencer for the nibble-wide reduction datapath: accepts an operand and op code, folds NIB bits per cycle.
// Optional macro REDUCE_EARLY_EXIT_EN lets AND/NAND/OR/NOR leave RUN as soon as the result is decided.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | folding one nibble per cycle into acc
// DONE  | result presented, held until out_ready
module reduction_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int NIB   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_res,
    output logic [2:0]       out_op,
    output logic             out_err,
    output logic             busy
);

    localparam int BEATS = WIDTH / NIB;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sreg;
    logic [2:0]       op_q;
    logic             acc;
    logic [CNT_W-1:0] cnt;
    logic [NIB-1:0]   nib;
    logic             acc_fold;
    logic             fold_done;
    logic             accept;
    logic             op_illegal;
    logic             op_q_illegal;
    logic             and_family;
    logic             or_family;

    assign nib          = sreg[NIB-1:0];
    assign accept       = in_valid && (state == IDLE);
    assign op_illegal   = (in_op[2:1] == 2'b11);
    assign op_q_illegal = (op_q[2:1] == 2'b11);
    assign and_family   = (op_q[2:1] == 2'b00);
    assign or_family    = (op_q[2:1] == 2'b01);

    always_comb begin
        acc_fold = acc ^ (^nib);
        if (and_family) begin
            acc_fold = acc & (&nib);
        end else if (or_family) begin
            acc_fold = acc | (|nib);
        end
    end

`ifdef REDUCE_EARLY_EXIT_EN
    // Once AND reaches 0 or OR reaches 1 the remaining nibbles cannot change the result.
    assign fold_done = (cnt == LAST_BEAT) || (and_family && !acc_fold) || (or_family && acc_fold);
`else
    assign fold_done = (cnt == LAST_BEAT);
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = op_illegal ? DONE : RUN;
                end
            end
            RUN: begin
                if (fold_done) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg <= '0;
            op_q <= '0;
            acc  <= 1'b0;
            cnt  <= '0;
        end else if (accept) begin
            sreg <= in_data;
            op_q <= in_op;
            acc  <= (in_op[2:1] == 2'b00);
            cnt  <= '0;
        end else if (state == RUN) begin
            sreg <= sreg >> NIB;
            acc  <= acc_fold;
            cnt  <= cnt + CNT_W'(1);
        end
    end

    // Odd op codes are the inverted variants; illegal ops report a zero result.
    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign out_op    = op_q;
    assign out_err   = (state == DONE) && op_q_illegal;
    assign out_res   = (state == DONE) && !op_q_illegal && (acc ^ op_q[0]);

endmodule

// File: tb/tb_reduction_seq_ctrl.sv
// Self-checking bench for reduction_seq_ctrl: directed vector table, hand sequences and random
// requests checked against an arithmetic reference model.
module tb_reduction_seq_ctrl;

    localparam int WIDTH = 16;
    localparam int NIB   = 4;
    localparam int BEATS = WIDTH / NIB;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_res;
    logic [2:0]       out_op;
    logic             out_err;
    logic             busy;

    int checks = 0;
    int errors = 0;

    reduction_seq_ctrl #(.WIDTH(WIDTH), .NIB(NIB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_res  (out_res),
        .out_op   (out_op),
        .out_err  (out_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] data;
        logic        res;
        logic        err;
        int          lat_full;
        int          lat_early;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: result from whole-word arithmetic, latency from the first deciding nibble.
    function automatic void model(input logic [2:0] op, input logic [15:0] d,
                                  output logic res, output logic err, output int lat);
        logic base;
        logic found;
        int   nibv;
        err   = 1'b0;
        lat   = BEATS + 1;
        found = 1'b0;
        if (op >= 3'd6) begin
            res = 1'b0;
            err = 1'b1;
            lat = 1;
            return;
        end
        case (op / 2)
            0:       base = (d == 16'hFFFF);
            1:       base = (d != 16'h0000);
            default: base = ($countones(d) % 2) == 1;
        endcase
        res = base ^ op[0];
`ifdef REDUCE_EARLY_EXIT_EN
        for (int i = 0; i < BEATS; i++) begin
            nibv = (d >> (NIB * i)) & 15;
            if (!found && (op / 2 == 0) && nibv != 15) begin
                lat   = i + 2;
                found = 1'b1;
            end
            if (!found && (op / 2 == 1) && nibv != 0) begin
                lat   = i + 2;
                found = 1'b1;
            end
        end
`else
        nibv = 0;
`endif
    endfunction

    task automatic run_txn(input logic [2:0] op, input logic [15:0] data, input int bp,
                           input logic exp_res, input logic exp_err, input int exp_lat,
                           input string tag);
        int lat;
        chk({tag, " in_ready idle"}, in_ready, 1);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        tick();
        // keep in_valid high with junk to show it is ignored outside IDLE
        in_op    = 3'($urandom);
        in_data  = 16'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " out_res"}, out_res, exp_res);
        chk({tag, " out_err"}, out_err, exp_err);
        chk({tag, " out_op"}, out_op, op);
        chk({tag, " busy done"}, busy, 1);
        for (int k = 0; k < bp; k++) begin
            tick();
            chk({tag, " held valid"}, out_valid, 1);
            chk({tag, " held res"}, out_res, exp_res);
            chk({tag, " held err"}, out_err, exp_err);
            chk({tag, " held op"}, out_op, op);
            chk({tag, " held in_ready"}, in_ready, 0);
            chk({tag, " held busy"}, busy, 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, " in_ready after"}, in_ready, 1);
        chk({tag, " valid after"}, out_valid, 0);
        chk({tag, " busy after"}, busy, 0);
    endtask

    initial begin
        logic        m_res;
        logic        m_err;
        int          m_lat;
        logic [2:0]  r_op;
        logic [15:0] r_data;
        int          sel;

        vecs[0] = '{3'd0, 16'hFFFF, 1'b1, 1'b0, 5, 5};
        vecs[1] = '{3'd5, 16'h0001, 1'b0, 1'b0, 5, 5};
        vecs[2] = '{3'd4, 16'h0003, 1'b0, 1'b0, 5, 5};
        vecs[3] = '{3'd3, 16'h0000, 1'b1, 1'b0, 5, 5};
        vecs[4] = '{3'd0, 16'hFFF0, 1'b0, 1'b0, 5, 2};
        vecs[5] = '{3'd1, 16'h0F00, 1'b1, 1'b0, 5, 2};
        vecs[6] = '{3'd2, 16'h0010, 1'b1, 1'b0, 5, 3};
        vecs[7] = '{3'd6, 16'h1234, 1'b0, 1'b1, 1, 1};
        vecs[8] = '{3'd7, 16'hFFFF, 1'b0, 1'b1, 1, 1};
        vecs[9] = '{3'd4, 16'h8000, 1'b1, 1'b0, 5, 5};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_res", out_res, 0);
        chk("reset out_err", out_err, 0);
        chk("reset out_op", out_op, 0);
        chk("reset busy", busy, 0);
        chk("reset in_ready", in_ready, 1);

        foreach (vecs[i]) begin
`ifdef REDUCE_EARLY_EXIT_EN
            run_txn(vecs[i].op, vecs[i].data, 0, vecs[i].res, vecs[i].err, vecs[i].lat_early,
                    $sformatf("vec%0d", i));
`else
            run_txn(vecs[i].op, vecs[i].data, 0, vecs[i].res, vecs[i].err, vecs[i].lat_full,
                    $sformatf("vec%0d", i));
`endif
        end

        model(3'd2, 16'h0010, m_res, m_err, m_lat);
        run_txn(3'd2, 16'h0010, 3, 1'b1, 1'b0, m_lat, "or_backpressure");

        // reset during RUN must discard the pending result
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_data  = 16'hFFFF;
        tick();
        in_valid = 1'b0;
        tick();
        chk("midrun busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort in_ready", in_ready, 1);
        chk("abort busy", busy, 0);
        chk("abort out_op", out_op, 0);
        for (int k = 0; k < 8; k++) begin
            chk("abort no valid", out_valid, 0);
            tick();
        end

        // reset during DONE
        in_valid = 1'b1;
        in_op    = 3'd6;
        in_data  = 16'h0000;
        tick();
        in_valid = 1'b0;
        chk("done before rst", out_valid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("done abort valid", out_valid, 0);
        chk("done abort err", out_err, 0);
        chk("done abort in_ready", in_ready, 1);

        for (int n = 0; n < 40; n++) begin
            r_op = 3'($urandom_range(0, 7));
            sel  = $urandom_range(0, 4);
            case (sel)
                0:       r_data = 16'h0000;
                1:       r_data = 16'hFFFF;
                2:       r_data = 16'hFFFF ^ (16'h1 << $urandom_range(0, 15));
                3:       r_data = 16'h1 << $urandom_range(0, 15);
                default: r_data = 16'($urandom);
            endcase
            model(r_op, r_data, m_res, m_err, m_lat);
            run_txn(r_op, r_data, $urandom_range(0, 3), m_res, m_err, m_lat,
                    $sformatf("rnd%0d op%0d d%04h", n, r_op, r_data));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
